// File: rtl/reduct_pkg.sv
// Shared types and defaults for the reduction broadcast path.
package reduct_pkg;

   typedef enum logic {IDLE, EMIT} bcast_state_t;

   localparam int REDUCT_WIDTH = 16;

endpackage

// File: rtl/reduct_broadcast.sv
// Replays one reduced scalar as a valid/ready burst of in_count beats,
// reloading on the last beat so consecutive bursts run without a bubble.
module reduct_broadcast
   import reduct_pkg::*;
#(
   parameter int WIDTH = REDUCT_WIDTH,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [CNT_W-1:0] in_count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_idx,
   output logic             out_last,
   output logic             busy
);

   bcast_state_t     state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] idx_q, idx_d;

   logic emitting;
   logic at_last;
   logic accept;

   always_comb begin
      emitting = (state_q == EMIT);
      at_last  = (idx_q == cnt_q - CNT_W'(1));
      in_ready = !emitting || (out_ready && at_last);
      accept   = in_valid && in_ready;

      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;

      if (emitting && out_ready) begin
         if (at_last) state_d = IDLE;
         else         idx_d   = idx_q + CNT_W'(1);
      end

      // A nonzero accept overrides the last-beat return to IDLE; zero counts are dropped.
      if (accept && (in_count != '0)) begin
         data_d  = in_data;
         cnt_d   = in_count;
         idx_d   = '0;
         state_d = EMIT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      out_valid = emitting;
      out_data  = data_q;
      out_idx   = idx_q;
      out_last  = emitting && at_last;
      busy      = emitting;
   end

endmodule

// File: tb/tb_reduct_broadcast.sv
// Scoreboard bench for reduct_broadcast: stimulus queues expected beats,
// a negedge monitor pops and compares every transferred beat.
module tb_reduct_broadcast;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [7:0]  in_count;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [7:0]  out_idx;
   logic        out_last;
   logic        busy;

   typedef struct packed {
      logic [15:0] d;
      logic [7:0]  i;
      logic        l;
   } beat_t;

   beat_t exp_q[$];
   int    errors = 0;
   int    checks = 0;

   always #5 clk = ~clk;

   reduct_broadcast #(.WIDTH(16), .CNT_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_count (in_count),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_idx  (out_idx),
      .out_last (out_last),
      .busy     (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one value, wait (bounded) for acceptance, queue its expected beats.
   task automatic send(input logic [15:0] d, input logic [7:0] c);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_count = c;
      @(negedge clk);
      while (!in_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", (n < 1000), 1);
      for (int k = 0; k < int'(c); k++) begin
         exp_q.push_back('{d: d, i: k[7:0], l: (k == int'(c) - 1)});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 16'h0BAD;
   endtask

   // Monitor: compare transferred beats and hold-stability across stalls.
   logic        stalled = 1'b0;
   logic [15:0] held_d;
   logic [7:0]  held_i;
   logic        held_l;
   beat_t       b;

   always @(negedge clk) begin
      if (rst) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            chk("valid_held", out_valid, 1);
            if (out_valid) begin
               chk("stall_data", out_data, held_d);
               chk("stall_idx", out_idx, held_i);
               chk("stall_last", out_last, held_l);
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_beat: got data %0h idx %0d, expected no beat", out_data, out_idx);
            end else begin
               b = exp_q.pop_front();
               chk("beat_data", out_data, b.d);
               chk("beat_idx", out_idx, b.i);
               chk("beat_last", out_last, b.l);
            end
         end
         stalled = out_valid && !out_ready;
         held_d  = out_data;
         held_i  = out_idx;
         held_l  = out_last;
      end
   end

   initial begin
      int   n;
      logic pat [7];
      logic rdy [7];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_count  = '0;
      out_ready = 1'b0;
      step();
      step();
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_idx", out_idx, 0);
      chk("rst_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      rst = 1'b0;
      step();

      // 1. basic burst
      out_ready = 1'b1;
      send(16'hA5C3, 8'd3);
      chk("t1_first_valid", out_valid, 1);
      chk("t1_busy", busy, 1);
      step(); step(); step();
      chk("t1_idle_valid", out_valid, 0);
      chk("t1_idle_busy", busy, 0);

      // 2. backpressure
      out_ready = 1'b0;
      send(16'h1357, 8'd4);
      for (int i = 0; i < 7; i++) begin
         out_ready = pat[i];
         @(negedge clk);
         chk("t2_in_ready", in_ready, rdy[i]);
         step();
      end
      chk("t2_done_busy", busy, 0);
      out_ready = 1'b1;
      step();

      // 3. back-to-back, zero bubble
      send(16'h0011, 8'd2);
      send(16'h0022, 8'd2);
      chk("t3_nobubble_valid", out_valid, 1);
      chk("t3_nobubble_data", out_data, 16'h0022);
      chk("t3_nobubble_idx", out_idx, 0);
      step(); step();
      chk("t3_idle", out_valid, 0);

      // 4. zero count
      send(16'hFFFF, 8'd0);
      chk("t4_no_beat", out_valid, 0);
      chk("t4_busy", busy, 0);
      step();
      chk("t4_still_no_beat", out_valid, 0);
      send(16'h1234, 8'd1);
      chk("t4_data", out_data, 16'h1234);
      chk("t4_last", out_last, 1);
      chk("t4_idx", out_idx, 0);
      step();
      chk("t4_idle", out_valid, 0);

      // 5. reset mid-burst
      send(16'hBEEF, 8'd10);
      step(); step(); step();
      chk("t5_idx_before_rst", out_idx, 3);
      rst       = 1'b1;
      out_ready = 1'b0;
      step();
      chk("t5_rst_valid", out_valid, 0);
      chk("t5_rst_data", out_data, 0);
      chk("t5_rst_busy", busy, 0);
      rst = 1'b0;
      exp_q.delete();
      out_ready = 1'b1;
      send(16'h7777, 8'd2);
      chk("t5_restart_idx", out_idx, 0);
      chk("t5_restart_data", out_data, 16'h7777);
      step(); step();

      // 6. maximum count
      send(16'hCAFE, 8'hFF);
      n = 0;
      while (busy && n < 400) begin
         step();
         n++;
      end
      chk("t6_beats", n, 255);
      chk("t6_idle", out_valid, 0);

      step();
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
